srl_lane_checker: RTL and testbench

- Downstream consumer of a triple SRLC32E slice test: three 32-deep addressable shift-register lanes sharing CLK, CE, D and A[4:0].
- Snoops the same CE/D/A stimulus and keeps a golden 32-bit shift model.
- Compares each lane output Q[i] against the model tap every cycle.
- Reports sticky per-lane errors, saturating counters and first-failure capture, for readout over a board debug path.

---
 rtl/srl_test_pkg.sv | 29 ++
 rtl/srl_golden_model.sv | 45 ++++
 rtl/srl_lane_checker.sv | 113 +++++++++++
 tb/tb_srl_lane_checker.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/srl_test_pkg.sv
// ============================================================================
// Module      : srl_test_pkg
// Description : Shared types, sizes and helpers for the SRL lane checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package srl_test_pkg;

    localparam int SRL_DEPTH = 32;
    localparam int SRL_AW    = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Increment that sticks at the all-ones value of a WIDTH-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? value : value + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/srl_golden_model.sv
// ============================================================================
// Module      : srl_golden_model
// Description : Golden shift register mirroring the SRLs, plus fill tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module srl_golden_model
    import srl_test_pkg::*;
#(
    parameter int DEPTH = SRL_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic                     d,
    input  logic [$clog2(DEPTH)-1:0] addr,
    output logic                     tap,
    output logic                     valid
);

    localparam int KW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_model;
    logic [KW-1:0]    r_known;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_model <= '0;
            r_known <= '0;
        end else if (ce) begin
            r_model <= {r_model[DEPTH-2:0], d};
            if (r_known != KW'(DEPTH)) begin
                r_known <= r_known + KW'(1);
            end
        end
    end

    // Only bits shifted in since reset are trustworthy; SRL contents survive reset.
    assign tap   = r_model[addr];
    assign valid = (KW'(addr) < r_known);

endmodule

`default_nettype wire

// File: rtl/srl_lane_checker.sv
// ============================================================================
// Module      : srl_lane_checker
// Description : Compares SRL lane outputs against a golden shift model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module srl_lane_checker
    import srl_test_pkg::*;
#(
    parameter int LANES       = 3,
    parameter int DEPTH       = SRL_DEPTH,
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     EN,
    input  logic                     CLR,
    input  logic                     CE,
    input  logic                     D,
    input  logic [$clog2(DEPTH)-1:0] A,
    input  logic [LANES-1:0]         Q,
    output logic                     ERR,
    output logic [LANES-1:0]         ERR_LANE,
    output logic [CNT_W-1:0]         CHECK_CNT,
    output logic [CNT_W-1:0]         MISMATCH_CNT,
    output logic [$clog2(DEPTH)-1:0] FIRST_ERR_A,
    output logic [LANES-1:0]         FIRST_ERR_Q,
    output logic [1:0]               STATE
);

    state_t           r_state;
    logic             w_tap;
    logic             w_valid;
    logic             w_cmp;
    logic             w_any_mis;
    logic [LANES-1:0] w_lane_mis;

    srl_golden_model #(
        .DEPTH (DEPTH)
    ) u_model (
        .clk   (CLK),
        .rst_n (RST_N),
        .ce    (CE),
        .d     (D),
        .addr  (A),
        .tap   (w_tap),
        .valid (w_valid)
    );

    // Tap uses the pre-shift model: SRL Q reflects contents before this edge.
    assign w_cmp      = (r_state == ST_ARMED) && EN && w_valid;
    assign w_lane_mis = Q ^ {LANES{w_tap}};
    assign w_any_mis  = w_cmp && (|w_lane_mis);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (EN) r_state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (!EN) begin
                        r_state <= ST_IDLE;
                    end else if (STOP_ON_ERR && w_any_mis && !CLR) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (CLR || !EN) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ERR          <= 1'b0;
            ERR_LANE     <= '0;
            CHECK_CNT    <= '0;
            MISMATCH_CNT <= '0;
            FIRST_ERR_A  <= '0;
            FIRST_ERR_Q  <= '0;
        end else if (CLR) begin
            ERR          <= 1'b0;
            ERR_LANE     <= '0;
            CHECK_CNT    <= '0;
            MISMATCH_CNT <= '0;
            FIRST_ERR_A  <= '0;
            FIRST_ERR_Q  <= '0;
        end else if (w_cmp) begin
            CHECK_CNT <= CNT_W'(sat_inc(32'(CHECK_CNT), CNT_W));
            if (w_any_mis) begin
                MISMATCH_CNT <= CNT_W'(sat_inc(32'(MISMATCH_CNT), CNT_W));
                ERR          <= 1'b1;
                ERR_LANE     <= ERR_LANE | w_lane_mis;
                if (!ERR) begin
                    FIRST_ERR_A <= A;
                    FIRST_ERR_Q <= Q;
                end
            end
        end
    end

    assign STATE = r_state;

endmodule

`default_nettype wire

// File: tb/tb_srl_lane_checker.sv
// ============================================================================
// Module      : tb_srl_lane_checker
// Description : Self-checking bench; three checker configurations share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_srl_lane_checker;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       EN = 1'b0, CLR = 1'b0, CE = 1'b0, D = 1'b0;
    logic [4:0] A = '0;
    logic [2:0] Q = '0;

    logic        err_0, err_1, err_2;
    logic [2:0]  lane_0, lane_1, lane_2, fq_0, fq_1, fq_2;
    logic [15:0] chk_0, chk_1, mis_0, mis_1;
    logic [3:0]  chk_2, mis_2;
    logic [4:0]  fa_0, fa_1, fa_2;
    logic [1:0]  st_0, st_1, st_2;

    logic        o_err  [3];
    logic [2:0]  o_lane [3];
    logic [15:0] o_chk  [3];
    logic [15:0] o_mis  [3];
    logic [4:0]  o_fa   [3];
    logic [2:0]  o_fq   [3];
    logic [1:0]  o_st   [3];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    srl_lane_checker u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR), .CE(CE), .D(D), .A(A), .Q(Q),
        .ERR(err_0), .ERR_LANE(lane_0), .CHECK_CNT(chk_0), .MISMATCH_CNT(mis_0),
        .FIRST_ERR_A(fa_0), .FIRST_ERR_Q(fq_0), .STATE(st_0));

    srl_lane_checker #(.STOP_ON_ERR(1'b1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR), .CE(CE), .D(D), .A(A), .Q(Q),
        .ERR(err_1), .ERR_LANE(lane_1), .CHECK_CNT(chk_1), .MISMATCH_CNT(mis_1),
        .FIRST_ERR_A(fa_1), .FIRST_ERR_Q(fq_1), .STATE(st_1));

    srl_lane_checker #(.CNT_W(4)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .CLR(CLR), .CE(CE), .D(D), .A(A), .Q(Q),
        .ERR(err_2), .ERR_LANE(lane_2), .CHECK_CNT(chk_2), .MISMATCH_CNT(mis_2),
        .FIRST_ERR_A(fa_2), .FIRST_ERR_Q(fq_2), .STATE(st_2));

    assign o_err[0] = err_0;  assign o_err[1] = err_1;  assign o_err[2] = err_2;
    assign o_lane[0] = lane_0; assign o_lane[1] = lane_1; assign o_lane[2] = lane_2;
    assign o_chk[0] = chk_0;  assign o_chk[1] = chk_1;  assign o_chk[2] = {12'd0, chk_2};
    assign o_mis[0] = mis_0;  assign o_mis[1] = mis_1;  assign o_mis[2] = {12'd0, mis_2};
    assign o_fa[0] = fa_0;    assign o_fa[1] = fa_1;    assign o_fa[2] = fa_2;
    assign o_fq[0] = fq_0;    assign o_fq[1] = fq_1;    assign o_fq[2] = fq_2;
    assign o_st[0] = st_0;    assign o_st[1] = st_1;    assign o_st[2] = st_2;

    // Reference model: hist[k] is the bit shifted in k shifts ago.
    bit         hist[$];
    int         nshift;
    int         cmax [3]  = '{65535, 65535, 15};
    bit         stopc [3] = '{1'b0, 1'b1, 1'b0};
    int         m_st  [3];
    int         m_chk [3];
    int         m_mis [3];
    logic       m_err [3];
    logic [2:0] m_lane[3];
    logic [4:0] m_fa  [3];
    logic [2:0] m_fq  [3];

    task automatic model_reset();
        hist.delete();
        nshift = 0;
        for (int c = 0; c < 3; c++) begin
            m_st[c] = 0; m_chk[c] = 0; m_mis[c] = 0; m_err[c] = 1'b0;
            m_lane[c] = '0; m_fa[c] = '0; m_fq[c] = '0;
        end
    endtask

    function automatic logic [2:0] good_q(input logic [4:0] a);
        if (int'(a) < nshift) return hist[a] ? 3'b111 : 3'b000;
        return 3'($urandom_range(0, 7));
    endfunction

    // Applies one cycle of stimulus, advances the model, returns #1 after the edge.
    task automatic drive(input bit en, input bit clr, input bit ce, input bit d,
                         input logic [4:0] a, input logic [2:0] q);
        bit         valid;
        bit         cmp;
        logic [2:0] lm;
        EN = en; CLR = clr; CE = ce; D = d; A = a; Q = q;
        valid = int'(a) < nshift;
        lm = valid ? (q ^ (hist[a] ? 3'b111 : 3'b000)) : 3'b000;
        for (int c = 0; c < 3; c++) begin
            cmp = (m_st[c] == 1) && en && valid;
            if (clr) begin
                m_chk[c] = 0; m_mis[c] = 0; m_err[c] = 1'b0;
                m_lane[c] = '0; m_fa[c] = '0; m_fq[c] = '0;
            end else if (cmp) begin
                if (m_chk[c] < cmax[c]) m_chk[c]++;
                if (lm != 0) begin
                    if (m_mis[c] < cmax[c]) m_mis[c]++;
                    if (!m_err[c]) begin m_fa[c] = a; m_fq[c] = q; end
                    m_err[c] = 1'b1;
                    m_lane[c] = m_lane[c] | lm;
                end
            end
            case (m_st[c])
                0: if (en) m_st[c] = 1;
                1: if (!en) m_st[c] = 0;
                   else if (stopc[c] && cmp && lm != 0 && !clr) m_st[c] = 2;
                default: if (clr || !en) m_st[c] = 0;
            endcase
        end
        if (ce) begin
            hist.push_front(d);
            if (hist.size() > 32) void'(hist.pop_back());
            if (nshift < 32) nshift++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge CLK); #3;
        RST_N = 1'b0; EN = 1'b0; CLR = 1'b0; CE = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (err_0 !== 1'b0) begin bad++; $display("FAIL reset_err: got %0d want 0", err_0); end
        total++; if (lane_0 !== 3'b000) begin bad++; $display("FAIL reset_lane: got %b want 000", lane_0); end
        total++; if (chk_0 !== 16'd0) begin bad++; $display("FAIL reset_chk: got %0d want 0", chk_0); end
        total++; if (mis_0 !== 16'd0) begin bad++; $display("FAIL reset_mis: got %0d want 0", mis_0); end
        total++; if (st_0 !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", st_0); end
    endtask

    task automatic test_fill();
        logic [3:0] pat;
        pat = 4'b1011;
        apply_reset();
        drive(1, 0, 0, 0, 5'd31, 3'b000);
        total++; if (st_0 !== 2'd1) begin bad++; $display("FAIL fill_armed: got %0d want 1", st_0); end
        for (int i = 3; i >= 0; i--) drive(1, 0, 1, pat[i], 5'd31, 3'b101);
        for (int a = 0; a < 4; a++) drive(1, 0, 0, 0, 5'(a), good_q(5'(a)));
        total++; if (chk_0 !== 16'd4) begin bad++; $display("FAIL fill_chk: got %0d want 4", chk_0); end
        total++; if (err_0 !== 1'b0) begin bad++; $display("FAIL fill_err: got %0d want 0", err_0); end
        total++; if (mis_0 !== 16'd0) begin bad++; $display("FAIL fill_mis: got %0d want 0", mis_0); end
    endtask

    task automatic test_unknown();
        apply_reset();
        drive(1, 0, 0, 0, 5'd31, 3'b000);
        drive(1, 0, 1, 1, 5'd31, 3'b000);
        drive(1, 0, 1, 0, 5'd31, 3'b000);
        drive(1, 0, 0, 0, 5'd5, 3'b110);
        total++; if (chk_0 !== 16'd0) begin bad++; $display("FAIL unknown_chk: got %0d want 0", chk_0); end
        total++; if (err_0 !== 1'b0) begin bad++; $display("FAIL unknown_err: got %0d want 0", err_0); end
    endtask

    task automatic test_single_lane();
        logic [2:0] q;
        apply_reset();
        drive(1, 0, 0, 0, 5'd31, 3'b000);
        for (int i = 0; i < 32; i++) drive(1, 0, 1, 1'($urandom), 5'd31, 3'b000);
        q = good_q(5'd7) ^ 3'b010;
        drive(1, 0, 0, 0, 5'd7, q);
        total++; if (lane_0 !== 3'b010) begin bad++; $display("FAIL lane_flags: got %b want 010", lane_0); end
        total++; if (err_0 !== 1'b1) begin bad++; $display("FAIL lane_err: got %0d want 1", err_0); end
        total++; if (fa_0 !== 5'd7) begin bad++; $display("FAIL lane_first_a: got %0d want 7", fa_0); end
        total++; if (fq_0 !== q) begin bad++; $display("FAIL lane_first_q: got %b want %b", fq_0, q); end
        total++; if (mis_0 !== 16'd1) begin bad++; $display("FAIL lane_mis: got %0d want 1", mis_0); end
        total++; if (st_1 !== 2'd2) begin bad++; $display("FAIL halt_enter: got %0d want 2", st_1); end
    endtask

    task automatic test_halt();
        drive(1, 0, 0, 0, 5'd3, ~good_q(5'd3));
        drive(1, 0, 1, 1, 5'd9, ~good_q(5'd9));
        total++; if (chk_1 !== 16'd1) begin bad++; $display("FAIL halt_chk: got %0d want 1", chk_1); end
        total++; if (mis_1 !== 16'd1) begin bad++; $display("FAIL halt_mis: got %0d want 1", mis_1); end
        total++; if (fa_0 !== 5'd7) begin bad++; $display("FAIL first_hold: got %0d want 7", fa_0); end
        total++; if (mis_0 !== 16'd3) begin bad++; $display("FAIL nohalt_mis: got %0d want 3", mis_0); end
        drive(1, 1, 0, 0, 5'd3, 3'b000);
        total++; if (st_1 !== 2'd0) begin bad++; $display("FAIL halt_clr_state: got %0d want 0", st_1); end
        total++; if (chk_1 !== 16'd0) begin bad++; $display("FAIL halt_clr_chk: got %0d want 0", chk_1); end
        total++; if (err_1 !== 1'b0) begin bad++; $display("FAIL halt_clr_err: got %0d want 0", err_1); end
        drive(1, 0, 0, 0, 5'd3, good_q(5'd3));
        total++; if (st_1 !== 2'd1) begin bad++; $display("FAIL halt_rearm: got %0d want 1", st_1); end
    endtask

    task automatic test_clr_collision();
        drive(1, 0, 0, 0, 5'd4, ~good_q(5'd4));
        drive(1, 1, 0, 0, 5'd5, ~good_q(5'd5));
        total++; if (chk_0 !== 16'd0) begin bad++; $display("FAIL clr_col_chk: got %0d want 0", chk_0); end
        total++; if (mis_0 !== 16'd0) begin bad++; $display("FAIL clr_col_mis: got %0d want 0", mis_0); end
        total++; if (err_0 !== 1'b0) begin bad++; $display("FAIL clr_col_err: got %0d want 0", err_0); end
        total++; if (lane_0 !== 3'b000) begin bad++; $display("FAIL clr_col_lane: got %b want 000", lane_0); end
    endtask

    task automatic test_saturation();
        logic [4:0] a;
        for (int i = 0; i < 20; i++) begin
            a = 5'($urandom_range(0, 31));
            drive(1, 0, 1'($urandom), 1'($urandom), a, good_q(a));
        end
        total++; if (chk_2 !== 4'd15) begin bad++; $display("FAIL sat_chk4: got %0d want 15", chk_2); end
        total++; if (chk_0 !== 16'd20) begin bad++; $display("FAIL sat_chk16: got %0d want 20", chk_0); end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, 5'd2, ~good_q(5'd2));
        #3 RST_N = 1'b0;
        #1;
        total++; if (err_0 !== 1'b0) begin bad++; $display("FAIL arst_err: got %0d want 0", err_0); end
        total++; if (chk_0 !== 16'd0) begin bad++; $display("FAIL arst_chk: got %0d want 0", chk_0); end
        total++; if (fa_0 !== 5'd0) begin bad++; $display("FAIL arst_first_a: got %0d want 0", fa_0); end
        total++; if (st_0 !== 2'd0) begin bad++; $display("FAIL arst_state: got %0d want 0", st_0); end
        model_reset();
        @(posedge CLK); #1 RST_N = 1'b1;
    endtask

    task automatic test_random();
        logic [4:0] a;
        logic [2:0] q;
        bit         en;
        bit         clr;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            en  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 24) == 0);
            a   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            q   = good_q(a);
            if ($urandom_range(0, 9) == 0) q = q ^ 3'($urandom_range(1, 7));
            drive(en, clr, 1'($urandom), 1'($urandom), a, q);
            for (int c = 0; c < 3; c++) begin
                total++; if (o_err[c] !== m_err[c]) begin bad++; $display("FAIL rand_err[%0d] cyc %0d: got %0d want %0d", c, cyc, o_err[c], m_err[c]); end
                total++; if (o_lane[c] !== m_lane[c]) begin bad++; $display("FAIL rand_lane[%0d] cyc %0d: got %b want %b", c, cyc, o_lane[c], m_lane[c]); end
                total++; if (o_chk[c] !== 16'(m_chk[c])) begin bad++; $display("FAIL rand_chk[%0d] cyc %0d: got %0d want %0d", c, cyc, o_chk[c], m_chk[c]); end
                total++; if (o_mis[c] !== 16'(m_mis[c])) begin bad++; $display("FAIL rand_mis[%0d] cyc %0d: got %0d want %0d", c, cyc, o_mis[c], m_mis[c]); end
                total++; if (o_fa[c] !== m_fa[c]) begin bad++; $display("FAIL rand_first_a[%0d] cyc %0d: got %0d want %0d", c, cyc, o_fa[c], m_fa[c]); end
                total++; if (o_fq[c] !== m_fq[c]) begin bad++; $display("FAIL rand_first_q[%0d] cyc %0d: got %b want %b", c, cyc, o_fq[c], m_fq[c]); end
                total++; if (o_st[c] !== 2'(m_st[c])) begin bad++; $display("FAIL rand_state[%0d] cyc %0d: got %0d want %0d", c, cyc, o_st[c], m_st[c]); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_unknown();
        test_single_lane();
        test_halt();
        test_clr_collision();
        test_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
